// File: rtl/move_link_ctrl.sv
// move_link_ctrl: link layer for the board-to-board move exchange.
// Shares one tx instance between outgoing moves and acknowledgements and
// adds ACK/timeout/retry, duplicate filtering and a sticky link error flag.
module move_link_ctrl #(
  parameter int CLK_HZ      = 65_000_000,
  parameter int ACK_TIMEOUT = CLK_HZ / 10,
  parameter int MAX_RETRY   = 3,
  parameter int PKT_LEN     = 8,
  parameter logic [PKT_LEN-1:0] ACK_CODE = 8'hAA
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [PKT_LEN-1:0]                 move_in,
  input  logic                               move_valid,
  input  logic                               my_turn,
  input  logic [PKT_LEN-1:0]                 rx_data,
  input  logic                               rx_ready,
  input  logic                               tx_busy,
  output logic                               tx_trigger,
  output logic [PKT_LEN-1:0]                 tx_data,
  output logic [PKT_LEN-1:0]                 move_rx_out,
  output logic                               move_rx_valid,
  output logic                               link_busy,
  output logic                               link_err,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [CW-1:0] TOUT_LAST = CW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] TX_MOVE  = 3'd1;
  localparam logic [2:0] WAIT_ACK = 3'd2;
  localparam logic [2:0] TX_ACK   = 3'd3;
  localparam logic [2:0] ERROR    = 3'd4;

  // Phases of the shared transmit handshake
  localparam logic [1:0] PH_WAIT = 2'd0;  // waiting for tx to go idle
  localparam logic [1:0] PH_RISE = 2'd1;  // trigger issued, waiting for tx_busy
  localparam logic [1:0] PH_FALL = 2'd2;  // byte shifting, waiting for tx_busy to drop

  logic [2:0]         state_reg, state_next;
  logic [2:0]         ret_state_reg, ret_state_next;
  logic [1:0]         phase_reg, phase_next;
  logic [PKT_LEN-1:0] move_reg, move_next;
  logic               ack_pending_reg, ack_pending_next;
  logic [CW-1:0]      tout_reg, tout_next;
  logic [RW-1:0]      retry_reg, retry_next;
  logic               trigger_reg, trigger_next;
  logic [PKT_LEN-1:0] tx_data_reg, tx_data_next;
  logic [PKT_LEN-1:0] rx_out_reg, rx_out_next;
  logic               rx_valid_reg, rx_valid_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;

  logic rx_ack;
  logic rx_move;
  logic fire;
  logic fire_ack;
  logic start_ack;

  assign rx_ack  = rx_ready && (rx_data == ACK_CODE);
  assign rx_move = rx_ready && (rx_data != ACK_CODE);

  // Next-state logic: FSM, transmit handshake, receive path and counters
  always_comb begin
    state_next       = state_reg;
    ret_state_next   = ret_state_reg;
    phase_next       = phase_reg;
    move_next        = move_reg;
    ack_pending_next = ack_pending_reg;
    tout_next        = tout_reg;
    retry_next       = retry_reg;
    trigger_next     = 1'b0;
    tx_data_next     = tx_data_reg;
    rx_out_next      = rx_out_reg;
    rx_valid_next    = 1'b0;
    busy_next        = busy_reg;
    err_next         = err_reg;
    fire             = 1'b0;
    fire_ack         = 1'b0;
    start_ack        = 1'b0;

    // Every non-ACK byte must be acknowledged; it is delivered only when the
    // remote side owns the turn, otherwise it is a resend whose ACK was lost.
    if (rx_move) begin
      ack_pending_next = 1'b1;
      if (!my_turn) begin
        rx_out_next   = rx_data;
        rx_valid_next = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        // A pending ACK owns the cycle; a move offered alongside it is dropped.
        if (ack_pending_reg) begin
          if (!tx_busy) begin
            start_ack = 1'b1;
          end
        end else if (move_valid) begin
          move_next  = move_in;
          busy_next  = 1'b1;
          retry_next = '0;
          state_next = TX_MOVE;
          phase_next = PH_WAIT;
        end
      end

      TX_MOVE, TX_ACK: begin
        case (phase_reg)
          PH_WAIT: begin
            if (!tx_busy) begin
              fire     = 1'b1;
              fire_ack = (state_reg == TX_ACK);
            end
          end
          PH_RISE: begin
            if (tx_busy) begin
              phase_next = PH_FALL;
            end
          end
          default: begin
            if (!tx_busy) begin
              phase_next = PH_WAIT;
              if (state_reg == TX_MOVE) begin
                state_next = WAIT_ACK;
                tout_next  = '0;
              end else begin
                state_next = ret_state_reg;
              end
            end
          end
        endcase
      end

      WAIT_ACK: begin
        if (rx_ack) begin
          // ACK beats a coincident terminal count
          state_next = IDLE;
          busy_next  = 1'b0;
        end else if (tout_reg == TOUT_LAST) begin
          if (retry_reg < RETRY_MAX) begin
            retry_next = retry_reg + RW'(1);
            state_next = TX_MOVE;
            phase_next = PH_WAIT;
            // Resend straight away when tx is free so the retransmit lands
            // one cycle after the terminal count.
            if (!tx_busy) begin
              fire = 1'b1;
            end
          end else begin
            state_next = ERROR;
            busy_next  = 1'b0;
            err_next   = 1'b1;
          end
        end else begin
          // Counter only advances in WAIT_ACK, so it is frozen during TX_ACK
          tout_next = tout_reg + CW'(1);
          if (ack_pending_reg && !tx_busy) begin
            start_ack = 1'b1;
          end
        end
      end

      ERROR: begin
        if (ack_pending_reg && !tx_busy) begin
          start_ack = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (start_ack) begin
      state_next     = TX_ACK;
      ret_state_next = state_reg;
      fire           = 1'b1;
      fire_ack       = 1'b1;
    end

    // Trigger and byte change together; the byte then holds until next trigger
    if (fire) begin
      trigger_next = 1'b1;
      tx_data_next = fire_ack ? ACK_CODE : move_reg;
      phase_next   = PH_RISE;
    end

    // The flag drops once the ACK is committed to tx; a byte arriving in the
    // same cycle or later re-arms it so it gets its own acknowledgement.
    if (fire_ack) begin
      ack_pending_next = rx_move;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg       <= IDLE;
      ret_state_reg   <= IDLE;
      phase_reg       <= PH_WAIT;
      move_reg        <= '0;
      ack_pending_reg <= 1'b0;
      tout_reg        <= '0;
      retry_reg       <= '0;
      trigger_reg     <= 1'b0;
      tx_data_reg     <= '0;
      rx_out_reg      <= '0;
      rx_valid_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ret_state_reg   <= ret_state_next;
      phase_reg       <= phase_next;
      move_reg        <= move_next;
      ack_pending_reg <= ack_pending_next;
      tout_reg        <= tout_next;
      retry_reg       <= retry_next;
      trigger_reg     <= trigger_next;
      tx_data_reg     <= tx_data_next;
      rx_out_reg      <= rx_out_next;
      rx_valid_reg    <= rx_valid_next;
      busy_reg        <= busy_next;
      err_reg         <= err_next;
    end
  end

  assign tx_trigger    = trigger_reg;
  assign tx_data       = tx_data_reg;
  assign move_rx_out   = rx_out_reg;
  assign move_rx_valid = rx_valid_reg;
  assign link_busy     = busy_reg;
  assign link_err      = err_reg;
  assign retry_cnt     = retry_reg;

endmodule
